// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
// Used by hazard_ctrl and wait_timer.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } state_t;

endpackage

// File: rtl/wait_timer.sv
// Loadable saturating counter of consecutive frozen cycles.
// Its terminal-count compare tells the FSM that memory has hung.
module wait_timer
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    localparam logic [WAIT_CNT_W-1:0] TERM_CNT = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    logic [WAIT_CNT_W-1:0] wait_cnt_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;

    // NOTE: give every combinational output a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (load) begin
            wait_cnt_d = WAIT_CNT_W'(1);
        end else if (inc && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign timeout = (wait_cnt_q == TERM_CNT);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller driving the stage-register enables and flushes of the 5-stage core.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead_ex,
    input  logic [REG_ADDR_W-1:0] rdAddr_ex,
    input  logic [REG_ADDR_W-1:0] rs1Addr_id,
    input  logic [REG_ADDR_W-1:0] rs2Addr_id,
    input  logic                  rs1Used_id,
    input  logic                  rs2Used_id,
    input  logic                  BranchTaken_ex,
    input  logic                  MemAccess_mem,
    input  logic                  dmemReady,
    output logic                  PC_en,
    output logic                  IFID_en,
    output logic                  IDEX_en,
    output logic                  EXMEM_en,
    output logic                  IFID_flush,
    output logic                  IDEX_flush,
    output logic                  MEMWB_flush,
    output logic                  memErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stallCycles,
    output logic [CNT_W-1:0]      flushCount
`endif
);

    state_t state_d, state_q;
    logic   mem_err_d, mem_err_q;
    logic   freeze, load_use;
    logic   tmr_load, tmr_clear, tmr_inc, tmr_timeout;

    assign freeze   = MemAccess_mem & ~dmemReady;
    assign load_use = MemRead_ex & (rdAddr_ex != '0) &
                      ((rs1Used_id & (rdAddr_ex == rs1Addr_id)) |
                       (rs2Used_id & (rdAddr_ex == rs2Addr_id)));

    wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .clear  (tmr_clear),
        .inc    (tmr_inc),
        .timeout(tmr_timeout)
    );

    // Ready on the final frozen cycle is checked before the timeout, so it wins.
    always_comb begin
        state_d   = state_q;
        mem_err_d = mem_err_q;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        tmr_inc   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d  = WAIT;
                    tmr_load = 1'b1;
                end
            end
            WAIT: begin
                if (!freeze) begin
                    state_d   = RUN;
                    tmr_clear = 1'b1;
                end else if (tmr_timeout) begin
                    state_d   = ERROR;
                    mem_err_d = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign memErr = mem_err_q;

    always_comb begin
        PC_en       = 1'b1;
        IFID_en     = 1'b1;
        IDEX_en     = 1'b1;
        EXMEM_en    = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        MEMWB_flush = 1'b0;
        if (state_q == ERROR) begin
            PC_en    = 1'b0;
            IFID_en  = 1'b0;
            IDEX_en  = 1'b0;
            EXMEM_en = 1'b0;
        end else if (freeze) begin
            PC_en       = 1'b0;
            IFID_en     = 1'b0;
            IDEX_en     = 1'b0;
            EXMEM_en    = 1'b0;
            MEMWB_flush = 1'b1;
        end else if (BranchTaken_ex) begin
            // The ID instruction is wrong-path, so any load-use hazard on it is moot.
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (load_use) begin
            PC_en      = 1'b0;
            IFID_en    = 1'b0;
            IDEX_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!PC_en && (state_q != ERROR)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (IFID_flush || IDEX_flush) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCycles = stall_cnt_q;
    assign flushCount  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus randomized traffic
// compared against a cycle-level reference model of the controller's rules.
module tb_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       MemRead_ex = 1'b0;
    logic [4:0] rdAddr_ex = '0;
    logic [4:0] rs1Addr_id = '0;
    logic [4:0] rs2Addr_id = '0;
    logic       rs1Used_id = 1'b0;
    logic       rs2Used_id = 1'b0;
    logic       BranchTaken_ex = 1'b0;
    logic       MemAccess_mem = 1'b0;
    logic       dmemReady = 1'b1;
    logic       PC_en, IFID_en, IDEX_en, EXMEM_en;
    logic       IFID_flush, IDEX_flush, MEMWB_flush, memErr;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCycles, flushCount;
`endif

    hazard_ctrl #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .MemRead_ex    (MemRead_ex),
        .rdAddr_ex     (rdAddr_ex),
        .rs1Addr_id    (rs1Addr_id),
        .rs2Addr_id    (rs2Addr_id),
        .rs1Used_id    (rs1Used_id),
        .rs2Used_id    (rs2Used_id),
        .BranchTaken_ex(BranchTaken_ex),
        .MemAccess_mem (MemAccess_mem),
        .dmemReady     (dmemReady),
        .PC_en         (PC_en),
        .IFID_en       (IFID_en),
        .IDEX_en       (IDEX_en),
        .EXMEM_en      (EXMEM_en),
        .IFID_flush    (IFID_flush),
        .IDEX_flush    (IDEX_flush),
        .MEMWB_flush   (MEMWB_flush),
        .memErr        (memErr)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stallCycles   (stallCycles),
        .flushCount    (flushCount)
`endif
    );

    always #5 clk = ~clk;

    // Output vector: {PC_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_flush, MEMWB_flush, memErr}
    logic [7:0] obs_v;
    assign obs_v = {PC_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_flush, MEMWB_flush, memErr};

    int checks   = 0;
    int failures = 0;

    // Reference model: error flag, length of the current frozen run, perf totals.
    bit m_err   = 1'b0;
    int m_run   = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit lu_f(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                                input logic [4:0] r2, input logic u1, input logic u2);
        return mr && (rd != 0) && ((u1 && rd == r1) || (u2 && rd == r2));
    endfunction

    function automatic logic [7:0] exp_out(input bit err, input bit fr, input bit br, input bit lu);
        if (err) return 8'b0000_0001;
        if (fr)  return 8'b0000_0010;
        if (br)  return 8'b1111_1100;
        if (lu)  return 8'b0011_0100;
        return 8'b1111_0000;
    endfunction

    task automatic model_clear();
        m_err   = 1'b0;
        m_run   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic idle_inputs();
        MemRead_ex     = 1'b0;
        rdAddr_ex      = '0;
        rs1Addr_id     = '0;
        rs2Addr_id     = '0;
        rs1Used_id     = 1'b0;
        rs2Used_id     = 1'b0;
        BranchTaken_ex = 1'b0;
        MemAccess_mem  = 1'b0;
        dmemReady      = 1'b1;
    endtask

    task automatic step(input string tag, input logic mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                        input logic u2, input logic br, input logic ma, input logic rdy);
        logic [7:0] e;
        bit fr;
        @(negedge clk);
        MemRead_ex     = mr;
        rdAddr_ex      = rd;
        rs1Addr_id     = r1;
        rs2Addr_id     = r2;
        rs1Used_id     = u1;
        rs2Used_id     = u2;
        BranchTaken_ex = br;
        MemAccess_mem  = ma;
        dmemReady      = rdy;
        #1;
        fr = ma && !rdy;
        e  = exp_out(m_err, fr, br, lu_f(mr, rd, r1, r2, u1, u2));
        chk(tag, {24'b0, obs_v}, {24'b0, e});
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_stall"}, stallCycles, m_stall);
        chk({tag, "_flush"}, flushCount, m_flush);
`endif
        @(posedge clk);
        if (!m_err) begin
            if (!e[7]) m_stall++;
            if (e[3] || e[2]) m_flush++;
            if (fr) begin
                m_run++;
                if (m_run == TO) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1;
        model_clear();
        chk("reset_out", {24'b0, obs_v}, {24'b0, exp_out(0, 0, 0, 0)});
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reset raised between edges must take effect without waiting for a clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk(tag, {24'b0, obs_v}, {24'b0, exp_out(0, 0, 0, 0)});
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        #1;
        chk("reset_state", {24'b0, obs_v}, {24'b0, exp_out(0, 0, 0, 0)});
        do_reset();

        // Load-use on rs1, then the load moves to MEM and the stall lifts.
        step("lu_rs1",        1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 1);
        step("lu_release",    0, 5'd0, 5'd5, 5'd0, 1, 0, 0, 1, 1);
        step("lu_rs2",        1, 5'd7, 5'd1, 5'd7, 1, 1, 0, 0, 1);
        // No false hazards: x0 destination, or matching rs2 that is not read.
        step("no_lu_x0",      1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 1);
        step("no_lu_unused",  1, 5'd9, 5'd3, 5'd9, 1, 0, 0, 0, 1);
        step("no_lu_notload", 0, 5'd9, 5'd9, 5'd9, 1, 1, 0, 0, 1);
        // Branch masks a simultaneous load-use.
        step("br_over_lu",    1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 1);
        step("default",       0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);

        // Three frozen cycles with a load-use pending, then ready.
        for (int i = 0; i < 3; i++) step("mem_wait", 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 0);
        step("mem_ready_lu",  1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1, 1);
        step("after_wait",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);

        // Ready on the last allowed frozen cycle: no error.
        for (int i = 0; i < TO - 1; i++) step("to_edge_wait", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        step("to_edge_ready", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
        step("to_edge_run",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);

        // Full timeout into ERROR; outputs stay dead whatever the inputs do.
        for (int i = 0; i < TO; i++) step("timeout_wait", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        step("error_br",      0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
        step("error_lu",      1, 5'd4, 5'd4, 5'd0, 1, 0, 0, 1, 1);
        chk("mem_err_model",  {31'b0, memErr}, 32'd1);
        async_reset("async_reset_error");
        step("post_err_run",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);

        // Reset in the middle of WAIT restarts the frozen-run count.
        for (int i = 0; i < TO - 1; i++) step("mid_wait", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        async_reset("async_reset_wait");
        for (int i = 0; i < TO - 1; i++) step("rewait", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        step("rewait_ready",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);

`ifdef HAZARD_PERF_CNT_EN
        // Two load-use stalls plus one branch from a clean reset.
        do_reset();
        step("perf_lu1",      1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 1);
        step("perf_gap",      0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
        step("perf_lu2",      1, 5'd6, 5'd0, 5'd6, 0, 1, 0, 0, 1);
        step("perf_br",       0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
        step("perf_idle",     0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
        chk("perf_stall_2",   stallCycles, 32'd2);
        chk("perf_flush_3",   flushCount, 32'd3);
`endif

        // Randomized traffic over a small register set so hazards are frequent.
        for (int i = 0; i < 600; i++) begin
            step("random",
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0));
            if (m_err && ($urandom_range(0, 3) == 0)) async_reset("random_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
